// File: rtl/steer_pkg.sv
// Shared types and header-field constants for the ingress packet steering stage.
package steer_pkg;

  // Class of a packet, decided from its first beat
  typedef enum logic [1:0] {
    CLS_CTRL,
    CLS_DATA,
    CLS_DROP
  } pkt_class_t;

  // Steering FSM: IDLE waits for a first beat, the others follow a packet to its tlast
  typedef enum logic [1:0] {
    IDLE,
    FWD_CTRL,
    FWD_DATA,
    DROP
  } steer_state_t;

  // Byte offsets inside the first 512-bit beat (byte n = tdata[8n+7:8n])
  localparam int ETH_TYPE_OFF   = 12;
  localparam int INNER_TYPE_OFF = 16;
  localparam int IP_PROTO_OFF   = 27;
  localparam int UDP_DPORT_OFF  = 40;

  localparam logic [15:0] ETH_VLAN  = 16'h8100;
  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [7:0]  PROTO_UDP = 8'h11;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream stage with full-throughput backpressure.
module axis_out_reg #(
  parameter int DW = 512,
  parameter int KW = 64,
  parameter int UW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_tdata_i,
  input  logic [KW-1:0] in_tkeep_i,
  input  logic [UW-1:0] in_tuser_i,
  input  logic          in_tlast_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_tdata_o,
  output logic [KW-1:0] out_tkeep_o,
  output logic [UW-1:0] out_tuser_o,
  output logic          out_tlast_o
);

  logic          valid_q;
  logic [DW-1:0] tdata_q;
  logic [KW-1:0] tkeep_q;
  logic [UW-1:0] tuser_q;
  logic          tlast_q;

  // Room exists when empty or when the held beat leaves this cycle
  assign in_ready_o = ~valid_q | out_ready_i;

  // Load a new beat when accepted; otherwise drain the held beat on egress
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      tdata_q <= in_tdata_i;
      tkeep_q <= in_tkeep_i;
      tuser_q <= in_tuser_i;
      tlast_q <= in_tlast_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_tdata_o = tdata_q;
  assign out_tkeep_o = tkeep_q;
  assign out_tuser_o = tuser_q;
  assign out_tlast_o = tlast_q;

endmodule

// File: rtl/ingress_pkt_steer.sv
// Steers Menshen control packets to the control stream, other VLAN packets to
// the data stream, and silently drops untagged packets; keeps per-class counters.
module ingress_pkt_steer
  import steer_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_ctrl_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_ctrl_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_ctrl_axis_tuser,
  output logic                              m_ctrl_axis_tvalid,
  output logic                              m_ctrl_axis_tlast,
  input  logic                              m_ctrl_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_data_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_data_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_data_axis_tuser,
  output logic                              m_data_axis_tvalid,
  output logic                              m_data_axis_tlast,
  input  logic                              m_data_axis_tready,
  output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  steer_state_t         state_q;
  pkt_class_t           idle_cls;
  pkt_class_t           cur_cls;
  logic [15:0]          eth_type;
  logic [15:0]          inner_type;
  logic [15:0]          udp_dport;
  logic [7:0]           ip_proto;
  logic                 ctrl_in_ready;
  logic                 data_in_ready;
  logic                 ctrl_in_valid;
  logic                 data_in_valid;
  logic                 beat_acc;
  logic [CNT_WIDTH-1:0] ctrl_cnt_q;
  logic [CNT_WIDTH-1:0] data_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  // Header fields are big-endian: the lower byte index is the high-order byte
  assign eth_type   = {s_axis_tdata[8*ETH_TYPE_OFF +: 8],   s_axis_tdata[8*(ETH_TYPE_OFF+1) +: 8]};
  assign inner_type = {s_axis_tdata[8*INNER_TYPE_OFF +: 8], s_axis_tdata[8*(INNER_TYPE_OFF+1) +: 8]};
  assign udp_dport  = {s_axis_tdata[8*UDP_DPORT_OFF +: 8],  s_axis_tdata[8*(UDP_DPORT_OFF+1) +: 8]};
  assign ip_proto   = s_axis_tdata[8*IP_PROTO_OFF +: 8];

  // Classify the beat on the bus as if it were a first beat
  always_comb begin
    idle_cls = CLS_DATA;
    if (eth_type != ETH_VLAN) begin
      idle_cls = CLS_DROP;
    end else if (inner_type == ETH_IPV4 && ip_proto == PROTO_UDP && udp_dport == CTRL_UDP_PORT) begin
      idle_cls = CLS_CTRL;
    end
  end

  // Mid-packet the class is implied by the FSM state; in IDLE it comes from the bus
  always_comb begin
    case (state_q)
      FWD_CTRL: cur_cls = CLS_CTRL;
      FWD_DATA: cur_cls = CLS_DATA;
      DROP:     cur_cls = CLS_DROP;
      default:  cur_cls = idle_cls;
    endcase
  end

  // Ready follows the selected output register; dropped beats are always sunk
  always_comb begin
    case (cur_cls)
      CLS_CTRL: s_axis_tready = ctrl_in_ready & ~reset;
      CLS_DATA: s_axis_tready = data_in_ready & ~reset;
      default:  s_axis_tready = ~reset;
    endcase
  end

  assign beat_acc      = s_axis_tvalid & s_axis_tready;
  assign ctrl_in_valid = s_axis_tvalid & ~reset & (cur_cls == CLS_CTRL);
  assign data_in_valid = s_axis_tvalid & ~reset & (cur_cls == CLS_DATA);

  // Track packet boundaries; only a multi-beat first beat leaves IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (beat_acc) begin
      if (s_axis_tlast) begin
        state_q <= IDLE;
      end else if (state_q == IDLE) begin
        case (idle_cls)
          CLS_CTRL: state_q <= FWD_CTRL;
          CLS_DATA: state_q <= FWD_DATA;
          default:  state_q <= DROP;
        endcase
      end
    end
  end

  // Count a packet when its tlast beat is accepted, independent of egress
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_cnt_q <= '0;
      data_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (beat_acc && s_axis_tlast) begin
      case (cur_cls)
        CLS_CTRL: ctrl_cnt_q <= ctrl_cnt_q + CNT_WIDTH'(1);
        CLS_DATA: data_cnt_q <= data_cnt_q + CNT_WIDTH'(1);
        default:  drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      endcase
    end
  end

  assign ctrl_pkt_cnt = ctrl_cnt_q;
  assign data_pkt_cnt = data_cnt_q;
  assign drop_pkt_cnt = drop_cnt_q;

  axis_out_reg #(
    .DW(C_S_AXIS_DATA_WIDTH),
    .KW(KW),
    .UW(C_S_AXIS_TUSER_WIDTH)
  ) u_ctrl_reg (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (ctrl_in_valid),
    .in_ready_o (ctrl_in_ready),
    .in_tdata_i (s_axis_tdata),
    .in_tkeep_i (s_axis_tkeep),
    .in_tuser_i (s_axis_tuser),
    .in_tlast_i (s_axis_tlast),
    .out_valid_o(m_ctrl_axis_tvalid),
    .out_ready_i(m_ctrl_axis_tready),
    .out_tdata_o(m_ctrl_axis_tdata),
    .out_tkeep_o(m_ctrl_axis_tkeep),
    .out_tuser_o(m_ctrl_axis_tuser),
    .out_tlast_o(m_ctrl_axis_tlast)
  );

  axis_out_reg #(
    .DW(C_S_AXIS_DATA_WIDTH),
    .KW(KW),
    .UW(C_S_AXIS_TUSER_WIDTH)
  ) u_data_reg (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (data_in_valid),
    .in_ready_o (data_in_ready),
    .in_tdata_i (s_axis_tdata),
    .in_tkeep_i (s_axis_tkeep),
    .in_tuser_i (s_axis_tuser),
    .in_tlast_i (s_axis_tlast),
    .out_valid_o(m_data_axis_tvalid),
    .out_ready_i(m_data_axis_tready),
    .out_tdata_o(m_data_axis_tdata),
    .out_tkeep_o(m_data_axis_tkeep),
    .out_tuser_o(m_data_axis_tuser),
    .out_tlast_o(m_data_axis_tlast)
  );

endmodule

// File: tb/tb_ingress_pkt_steer.sv
// Bench for ingress_pkt_steer: packet-level scoreboard plus directed literal checks.
module tb_ingress_pkt_steer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [511:0] m_ctrl_axis_tdata;
  logic [63:0]  m_ctrl_axis_tkeep;
  logic [127:0] m_ctrl_axis_tuser;
  logic         m_ctrl_axis_tvalid;
  logic         m_ctrl_axis_tlast;
  logic         m_ctrl_axis_tready = 1'b1;
  logic [511:0] m_data_axis_tdata;
  logic [63:0]  m_data_axis_tkeep;
  logic [127:0] m_data_axis_tuser;
  logic         m_data_axis_tvalid;
  logic         m_data_axis_tlast;
  logic         m_data_axis_tready = 1'b1;
  logic [31:0]  ctrl_pkt_cnt;
  logic [31:0]  data_pkt_cnt;
  logic [31:0]  drop_pkt_cnt;

  always #5 clk = ~clk;

  ingress_pkt_steer dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_ctrl_axis_tdata (m_ctrl_axis_tdata),
    .m_ctrl_axis_tkeep (m_ctrl_axis_tkeep),
    .m_ctrl_axis_tuser (m_ctrl_axis_tuser),
    .m_ctrl_axis_tvalid(m_ctrl_axis_tvalid),
    .m_ctrl_axis_tlast (m_ctrl_axis_tlast),
    .m_ctrl_axis_tready(m_ctrl_axis_tready),
    .m_data_axis_tdata (m_data_axis_tdata),
    .m_data_axis_tkeep (m_data_axis_tkeep),
    .m_data_axis_tuser (m_data_axis_tuser),
    .m_data_axis_tvalid(m_data_axis_tvalid),
    .m_data_axis_tlast (m_data_axis_tlast),
    .m_data_axis_tready(m_data_axis_tready),
    .ctrl_pkt_cnt      (ctrl_pkt_cnt),
    .data_pkt_cnt      (data_pkt_cnt),
    .drop_pkt_cnt      (drop_pkt_cnt)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  // Reference model state: class codes 0=ctrl 1=data 2=drop
  beat_t q_ctrl[$];
  beat_t q_data[$];
  int    m_cnt[3];
  bit    m_in_pkt = 1'b0;
  int    m_cls = 0;
  bit    chk_en = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [7:0] byt(input logic [511:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  // Classification rule applied to a first beat
  function automatic int decode(input logic [511:0] d);
    if ({byt(d, 12), byt(d, 13)} != 16'h8100) return 2;
    if ({byt(d, 16), byt(d, 17)} == 16'h0800 && byt(d, 27) == 8'h11 &&
        {byt(d, 40), byt(d, 41)} == 16'hF1F2) return 0;
    return 1;
  endfunction

  function automatic int exp_cls();
    return m_in_pkt ? m_cls : decode(s_axis_tdata);
  endfunction

  // A path accepts when its one-entry slot is empty or being emptied
  function automatic bit exp_ready();
    int c;
    if (reset) return 1'b0;
    c = exp_cls();
    if (c == 2) return 1'b1;
    if (c == 0) return (q_ctrl.size() == 0) || m_ctrl_axis_tready;
    return (q_data.size() == 0) || m_data_axis_tready;
  endfunction

  // Model update on each clock edge, from bench-driven inputs only
  always @(posedge clk) begin : model
    bit rdy;
    int c;
    beat_t b;
    if (reset) begin
      q_ctrl.delete();
      q_data.delete();
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
      m_in_pkt = 1'b0;
      chk_en = 1'b1;
    end else begin
      rdy = exp_ready();
      c = exp_cls();
      if (q_ctrl.size() > 0 && m_ctrl_axis_tready) void'(q_ctrl.pop_front());
      if (q_data.size() > 0 && m_data_axis_tready) void'(q_data.pop_front());
      if (s_axis_tvalid && rdy) begin
        b = '{d: s_axis_tdata, k: s_axis_tkeep, u: s_axis_tuser, l: s_axis_tlast};
        if (c == 0) q_ctrl.push_back(b);
        if (c == 1) q_data.push_back(b);
        if (s_axis_tlast) begin
          m_cnt[c] = m_cnt[c] + 1;
          m_in_pkt = 1'b0;
        end else begin
          m_in_pkt = 1'b1;
          m_cls = c;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_tready", {511'd0, s_axis_tready}, {511'd0, exp_ready()});
      chk("ctrl_valid", {511'd0, m_ctrl_axis_tvalid}, {511'd0, q_ctrl.size() != 0});
      if (q_ctrl.size() != 0) begin
        chk("ctrl_tdata", m_ctrl_axis_tdata, q_ctrl[0].d);
        chk("ctrl_tkeep", {448'd0, m_ctrl_axis_tkeep}, {448'd0, q_ctrl[0].k});
        chk("ctrl_tuser", {384'd0, m_ctrl_axis_tuser}, {384'd0, q_ctrl[0].u});
        chk("ctrl_tlast", {511'd0, m_ctrl_axis_tlast}, {511'd0, q_ctrl[0].l});
      end
      chk("data_valid", {511'd0, m_data_axis_tvalid}, {511'd0, q_data.size() != 0});
      if (q_data.size() != 0) begin
        chk("data_tdata", m_data_axis_tdata, q_data[0].d);
        chk("data_tkeep", {448'd0, m_data_axis_tkeep}, {448'd0, q_data[0].k});
        chk("data_tuser", {384'd0, m_data_axis_tuser}, {384'd0, q_data[0].u});
        chk("data_tlast", {511'd0, m_data_axis_tlast}, {511'd0, q_data[0].l});
      end
      chk("ctrl_cnt", {480'd0, ctrl_pkt_cnt}, {480'd0, 32'(m_cnt[0])});
      chk("data_cnt", {480'd0, data_pkt_cnt}, {480'd0, 32'(m_cnt[1])});
      chk("drop_cnt", {480'd0, drop_pkt_cnt}, {480'd0, 32'(m_cnt[2])});
    end
  end

  function automatic beat_t mk(input logic [15:0] et, input logic [15:0] tci, input logic [15:0] inner,
                               input logic [7:0] proto, input logic [15:0] dport, input int seed,
                               input logic last);
    beat_t b;
    b.d = {16{32'hA5C30000 + 32'(seed)}};
    b.d[8*12 +: 8] = et[15:8];    b.d[8*13 +: 8] = et[7:0];
    b.d[8*14 +: 8] = tci[15:8];   b.d[8*15 +: 8] = tci[7:0];
    b.d[8*16 +: 8] = inner[15:8]; b.d[8*17 +: 8] = inner[7:0];
    b.d[8*27 +: 8] = proto;
    b.d[8*40 +: 8] = dport[15:8]; b.d[8*41 +: 8] = dport[7:0];
    b.k = '1;
    b.u = {4{32'h5EED0000 + 32'(seed)}};
    b.l = last;
    return b;
  endfunction

  function automatic beat_t raw(input int seed, input logic last);
    beat_t b;
    b.d = {16{32'h3C000000 ^ (32'(seed) * 32'h01010101)}};
    b.k = '1;
    b.u = {4{32'hB0B00000 + 32'(seed)}};
    b.l = last;
    return b;
  endfunction

  // Present one beat and hold it until accepted (bounded wait)
  task automatic send(input beat_t b);
    int n;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout actual=stalled expected=accepted");
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  beat_t b1, c1, c2, cs, u1, u2, u3, d1, d2, d3;

  initial begin
    b1 = mk(16'h8100, 16'h0001, 16'h0800, 8'h11, 16'h10E1, 1, 1'b1);
    c1 = mk(16'h8100, 16'h0002, 16'h0800, 8'h11, 16'hF1F2, 2, 1'b0);
    c2 = raw(3, 1'b1);
    cs = mk(16'h8100, 16'h0003, 16'h0800, 8'h11, 16'hF1F2, 4, 1'b1);
    u1 = mk(16'h0800, 16'h4500, 16'h0000, 8'h11, 16'hF1F2, 5, 1'b0);
    u2 = mk(16'h8100, 16'h0000, 16'h0800, 8'h11, 16'hF1F2, 6, 1'b0);
    u3 = raw(7, 1'b1);
    d1 = mk(16'h8100, 16'h0005, 16'h86DD, 8'h06, 16'h0050, 8, 1'b0);
    d2 = raw(9, 1'b0);
    d3 = raw(10, 1'b1);
    d3.k = '0;

    // Pin the classification model with hand-decided cases
    chk("model_dec_data", 512'(decode(b1.d)), 512'd1);
    chk("model_dec_ctrl", 512'(decode(c1.d)), 512'd0);
    chk("model_dec_drop", 512'(decode(u1.d)), 512'd2);
    chk("model_dec_v6", 512'(decode(d1.d)), 512'd1);

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", {511'd0, s_axis_tready}, 512'd0);
    chk("rst_ctrl_tdata", m_ctrl_axis_tdata, 512'd0);
    chk("rst_data_tdata", m_data_axis_tdata, 512'd0);
    chk("rst_data_tlast", {511'd0, m_data_axis_tlast}, 512'd0);
    reset = 1'b0;
    idle(2);

    // Single-beat DATA packet, visible one cycle after acceptance
    send(b1);
    chk("t1_data_valid", {511'd0, m_data_axis_tvalid}, 512'd1);
    chk("t1_data_tdata", m_data_axis_tdata, b1.d);
    chk("t1_ctrl_valid", {511'd0, m_ctrl_axis_tvalid}, 512'd0);
    chk("t1_data_cnt", {480'd0, data_pkt_cnt}, 512'd1);
    idle(2);

    // Two-beat CTRL packet; second beat carries no header
    send(c1);
    send(c2);
    idle(2);
    chk("t2_ctrl_cnt", {480'd0, ctrl_pkt_cnt}, 512'd1);

    // Untagged 3-beat packet: sunk entirely
    send(u1);
    send(u2);
    send(u3);
    idle(2);
    chk("t3_drop_cnt", {480'd0, drop_pkt_cnt}, 512'd1);
    chk("t3_data_cnt", {480'd0, data_pkt_cnt}, 512'd1);

    // Backpressure on the data output during a 3-beat DATA packet
    m_data_axis_tready = 1'b0;
    fork
      begin
        send(d1);
        send(d2);
        send(d3);
      end
      begin
        repeat (4) @(negedge clk);
        chk("t4_stall_tready", {511'd0, s_axis_tready}, 512'd0);
        chk("t4_hold_tdata", m_data_axis_tdata, d1.d);
        @(posedge clk);
        #1;
        m_data_axis_tready = 1'b1;
      end
    join
    idle(3);
    chk("t4_data_cnt", {480'd0, data_pkt_cnt}, 512'd2);

    // Stalled CTRL output does not block a following DATA packet
    m_ctrl_axis_tready = 1'b0;
    send(cs);
    send(b1);
    chk("t5_ctrl_held", {511'd0, m_ctrl_axis_tvalid}, 512'd1);
    chk("t5_ctrl_tdata", m_ctrl_axis_tdata, cs.d);
    chk("t5_data_valid", {511'd0, m_data_axis_tvalid}, 512'd1);
    idle(1);
    m_ctrl_axis_tready = 1'b1;
    idle(2);
    chk("t5_ctrl_cnt", {480'd0, ctrl_pkt_cnt}, 512'd2);
    chk("t5_data_cnt", {480'd0, data_pkt_cnt}, 512'd3);

    // Reset on beat 2 of a 3-beat DATA packet
    send(d1);
    s_axis_tdata = d2.d;
    s_axis_tlast = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_ctrl_valid", {511'd0, m_ctrl_axis_tvalid}, 512'd0);
    chk("t6_data_valid", {511'd0, m_data_axis_tvalid}, 512'd0);
    chk("t6_data_cnt", {480'd0, data_pkt_cnt}, 512'd0);
    chk("t6_ctrl_cnt", {480'd0, ctrl_pkt_cnt}, 512'd0);
    reset = 1'b0;
    send(cs);
    chk("t6_new_first_ctrl", {511'd0, m_ctrl_axis_tvalid}, 512'd1);
    idle(2);
    chk("t6_ctrl_cnt_after", {480'd0, ctrl_pkt_cnt}, 512'd1);
    chk("t6_data_cnt_after", {480'd0, data_pkt_cnt}, 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
